// File: rtl/cordic_vector_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cordic_vector_ctrl
// Purpose  : Upstream sequencer for a 16-bit CORDIC vectoring core. It
//            accepts (x,y) samples, folds the left half-plane into the
//            core's convergence range, runs the core once for the angle
//            (func=0) and once for the magnitude (func=1), applies the +/-pi
//            quadrant correction and presents {angle, magnitude}.
// Ports    : clk, rst (async, active-high)
//            in_valid_i / in_ready_o / in_x_i / in_y_i       - sample input
//            out_valid_o / out_ready_i / out_angle_o / out_mag_o - result
//            core_st_o / core_x_o / core_y_o / core_func_o   - core request
//            core_result_i                                   - core result
// Revision : 1.0 - initial release
// ============================================================================
module cordic_vector_ctrl #(
  parameter int CORE_LATENCY = 52,
  parameter int PI_CONST     = 51472
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] in_x_i,
  input  logic [15:0] in_y_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [16:0] out_angle_o,
  output logic [31:0] out_mag_o,
  output logic        core_st_o,
  output logic [15:0] core_x_o,
  output logic [15:0] core_y_o,
  output logic [3:0]  core_func_o,
  input  logic [31:0] core_result_i
);

  localparam int              CW         = $clog2(CORE_LATENCY + 2);
  // The drain counter runs CORE_LATENCY+1 .. 0, i.e. CORE_LATENCY+2 cycles.
  localparam logic [CW-1:0]   DRAIN_LOAD = CW'(CORE_LATENCY + 1);
  // Loaded in the issue cycle so it reaches zero in cycle issue+CORE_LATENCY.
  localparam logic [CW-1:0]   WAIT_LOAD  = CW'(CORE_LATENCY - 1);
  localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
  localparam logic [16:0]     PI_S17     = 17'(PI_CONST);

  localparam logic [2:0] S_DRAIN   = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_ISSUE_A = 3'd2;
  localparam logic [2:0] S_WAIT_A  = 3'd3;
  localparam logic [2:0] S_ISSUE_B = 3'd4;
  localparam logic [2:0] S_WAIT_B  = 3'd5;
  localparam logic [2:0] S_OUT     = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   cx_q, cx_d;
  logic [15:0]   cy_q, cy_d;
  logic          flip_q, flip_d;
  logic          ysgn_q, ysgn_d;
  logic [15:0]   angle_raw_q, angle_raw_d;
  logic [16:0]   angle_q, angle_d;
  logic [31:0]   mag_q, mag_d;
  logic [16:0]   angle_ext;
  logic [16:0]   angle_fix;

  // Two's-complement negate that maps -32768 to +32767 instead of wrapping.
  function automatic logic [15:0] sat_neg(input logic [15:0] v);
    return (v == 16'h8000) ? 16'h7FFF : (~v + 16'd1);
  endfunction

  // A folded sample sits at angle-pi (y>=0 side) or angle+pi; undo that here.
  assign angle_ext = {angle_raw_q[15], angle_raw_q};
  assign angle_fix = !flip_q ? angle_ext :
                     (ysgn_q ? (angle_ext - PI_S17) : (angle_ext + PI_S17));

  // State register. The core has no reset of its own, so any reset lands in
  // DRAIN long enough for an in-flight core operation to finish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_DRAIN;
      cnt_q   <= DRAIN_LOAD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx_q        <= '0;
      cy_q        <= '0;
      flip_q      <= 1'b0;
      ysgn_q      <= 1'b0;
      angle_raw_q <= '0;
      angle_q     <= '0;
      mag_q       <= '0;
    end else begin
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      flip_q      <= flip_d;
      ysgn_q      <= ysgn_d;
      angle_raw_q <= angle_raw_d;
      angle_q     <= angle_d;
      mag_q       <= mag_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    flip_d      = flip_q;
    ysgn_d      = ysgn_q;
    angle_raw_d = angle_raw_q;
    angle_d     = angle_q;
    mag_d       = mag_q;
    case (state_q)
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      S_IDLE: begin
        if (in_valid_i) begin
          if (in_x_i[15]) begin
            cx_d   = sat_neg(in_x_i);
            cy_d   = sat_neg(in_y_i);
            flip_d = 1'b1;
            ysgn_d = in_y_i[15];
          end else begin
            cx_d   = in_x_i;
            cy_d   = in_y_i;
            flip_d = 1'b0;
            ysgn_d = 1'b0;
          end
          // The origin has no defined angle; skip the core entirely.
          if (in_x_i == '0 && in_y_i == '0) begin
            angle_d = '0;
            mag_d   = '0;
            state_d = S_OUT;
          end else begin
            state_d = S_ISSUE_A;
          end
        end
      end
      S_ISSUE_A: begin
        state_d = S_WAIT_A;
        cnt_d   = WAIT_LOAD;
      end
      S_WAIT_A: begin
        if (cnt_q == '0) begin
          angle_raw_d = core_result_i[15:0];
          state_d     = S_ISSUE_B;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_ISSUE_B: begin
        state_d = S_WAIT_B;
        cnt_d   = WAIT_LOAD;
      end
      S_WAIT_B: begin
        if (cnt_q == '0) begin
          mag_d   = core_result_i;
          angle_d = angle_fix;
          state_d = S_OUT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_OUT: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: begin
        state_d = S_DRAIN;
        cnt_d   = DRAIN_LOAD;
      end
    endcase
  end

  // Outputs are decoded from state; func is held across the whole wait so the
  // core sees a stable request until its result is captured.
  always_comb begin
    in_ready_o  = (state_q == S_IDLE);
    out_valid_o = (state_q == S_OUT);
    core_st_o   = (state_q == S_ISSUE_A) || (state_q == S_ISSUE_B);
    core_func_o = ((state_q == S_ISSUE_B) || (state_q == S_WAIT_B)) ? 4'd1 : 4'd0;
  end

  assign core_x_o    = cx_q;
  assign core_y_o    = cy_q;
  assign out_angle_o = angle_q;
  assign out_mag_o   = mag_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_vector_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_vector_ctrl
// Purpose  : Directed self-checking bench for cordic_vector_ctrl, with a
//            behavioural vectoring core that returns programmed results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_vector_ctrl;

  localparam int L  = 52;
  localparam int PI = 51472;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = '0;
  logic [15:0] in_y = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [16:0] out_angle;
  logic [31:0] out_mag;
  logic        core_st;
  logic [15:0] core_x;
  logic [15:0] core_y;
  logic [3:0]  core_func;
  logic [31:0] core_result;

  always #5 clk = ~clk;

  cordic_vector_ctrl #(.CORE_LATENCY(L), .PI_CONST(PI)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_x_i       (in_x),
    .in_y_i       (in_y),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_angle_o  (out_angle),
    .out_mag_o    (out_mag),
    .core_st_o    (core_st),
    .core_x_o     (core_x),
    .core_y_o     (core_y),
    .core_func_o  (core_func),
    .core_result_i(core_result)
  );

  // ---------------- behavioural core ----------------
  int          cyc = 0;
  int          st_cyc = -1000;
  int          last_rst_cyc = 0;
  int          st_count = 0;
  int          st_double = 0;
  int          unstable = 0;
  logic        st_prev = 1'b0;
  logic [15:0] m_x = '0;
  logic [15:0] m_y = '0;
  logic [3:0]  m_func = '0;
  logic [1:0]  func_log = '0;
  logic [15:0] prog_angle = '0;
  logic [31:0] prog_mag = '0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    st_prev <= core_st;
    if (rst) last_rst_cyc <= cyc;
    if (core_st) begin
      st_count <= st_count + 1;
      if (st_prev) st_double <= st_double + 1;
      m_x      <= core_x;
      m_y      <= core_y;
      m_func   <= core_func;
      st_cyc   <= cyc;
      func_log <= {func_log[0], core_func[0]};
    end
    if (cyc == st_cyc + L && st_cyc > last_rst_cyc &&
        (core_x !== m_x || core_y !== m_y || core_func !== m_func))
      unstable <= unstable + 1;
  end

  assign core_result = (cyc != st_cyc + L) ? 32'hDEADBEEF :
                       (m_func == 4'd0)    ? {{16{prog_angle[15]}}, prog_angle} :
                       (m_func == 4'd1)    ? prog_mag : 32'hDEADBEEF;

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_mis = 0;
  int acc_cyc = 0;
  int st_before = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sx16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] sx17(input logic [16:0] v);
    return {{15{v[16]}}, v};
  endfunction

  // Count cycles from rst release until in_ready rises; in_valid is held by
  // the caller so the sample is accepted in that cycle.
  task automatic measure_drain(input string tag);
    int n;
    int sb;
    n  = 0;
    sb = st_count;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, ".len"}, n, L + 2);
    check_eq({tag, ".no_st"}, st_count, sb);
  endtask

  task automatic start_txn(input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] pa, input logic [31:0] pm);
    int n;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    prog_angle = pa;
    prog_mag   = pm;
    in_x       = x;
    in_y       = y;
    in_valid   = 1'b1;
    acc_cyc    = cyc;
    st_before  = st_count;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    int n;
    n = 0;
    while (!out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    lat = out_valid ? (cyc - acc_cyc) : -1;
  endtask

  task automatic finish_txn(input string tag, input int exp_ang, input logic [31:0] exp_mag,
                            input int exp_lat, input int exp_cx, input int exp_cy,
                            input int exp_sts);
    int lat;
    wait_out(lat);
    check_eq({tag, ".lat"}, lat, exp_lat);
    check_eq({tag, ".angle"}, sx17(out_angle), exp_ang);
    check_eq({tag, ".mag"}, out_mag, exp_mag);
    check_eq({tag, ".st_cnt"}, st_count - st_before, exp_sts);
    if (exp_sts > 0) begin
      check_eq({tag, ".core_x"}, sx16(m_x), exp_cx);
      check_eq({tag, ".core_y"}, sx16(m_y), exp_cy);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, ".consumed"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    int   lat;
    logic [16:0] sa;
    logic [31:0] sm;
    logic stable;
    logic rdy_seen;

    // Reset state while rst is held
    in_x = 16'd16384;
    in_y = 16'd16384;
    repeat (3) @(negedge clk);
    check_eq("rst.out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst.in_ready",  {31'b0, in_ready},  32'd0);
    check_eq("rst.core_st",   {31'b0, core_st},   32'd0);
    check_eq("rst.core_func", {28'b0, core_func}, 32'd0);
    check_eq("rst.core_xy",   {core_x, core_y},   32'd0);
    check_eq("rst.angle",     sx17(out_angle),    32'd0);
    check_eq("rst.mag",       out_mag,            32'd0);

    // Drain with in_valid held, then the right-half-plane sample goes in
    in_valid = 1'b1;
    rst      = 1'b0;
    measure_drain("drain0");
    prog_angle = 16'd12868;
    prog_mag   = 32'h0000_5A82;
    acc_cyc    = cyc;
    st_before  = st_count;
    @(negedge clk);
    in_valid = 1'b0;
    finish_txn("rhp", 12868, 32'h0000_5A82, 2 * L + 3, 16384, 16384, 2);
    check_eq("rhp.func_order", {30'b0, func_log}, 32'd1);

    // Right half-plane, negative y: no correction
    start_txn(16'd1000, -16'sd2000, -16'sd4000, 32'd2236);
    finish_txn("rhp_neg", -4000, 32'd2236, 2 * L + 3, 1000, -2000, 2);

    // Folding
    start_txn(-16'sd100, 16'd0, 16'd0, 32'd100);
    finish_txn("fold_ypos", 51472, 32'd100, 2 * L + 3, 100, 0, 2);
    start_txn(-16'sd100, -16'sd50, 16'd7600, 32'd112);
    finish_txn("fold_yneg", -43872, 32'd112, 2 * L + 3, 100, 50, 2);

    // Saturating negate; negative raw angle is sign-extended before +pi
    start_txn(16'h8000, 16'd5, -16'sd10, 32'd32767);
    finish_txn("sat", 51462, 32'd32767, 2 * L + 3, 32767, -5, 2);

    // Zero bypass
    start_txn(16'd0, 16'd0, 16'd1, 32'd1);
    finish_txn("zero", 0, 32'd0, 1, 0, 0, 0);

    // Backpressure with a pending input, then simultaneous consume + in_valid
    start_txn(16'd3000, -16'sd3000, -16'sd6434, 32'd4243);
    wait_out(lat);
    check_eq("bp.lat", lat, 2 * L + 3);
    check_eq("bp.angle", sx17(out_angle), -6434);
    sa       = out_angle;
    sm       = out_mag;
    stable   = 1'b1;
    rdy_seen = 1'b0;
    in_x     = 16'd0;
    in_y     = 16'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_angle !== sa || out_mag !== sm || !out_valid) stable = 1'b0;
      if (in_ready) rdy_seen = 1'b1;
    end
    check_eq("bp.stable", {31'b0, stable}, 32'd1);
    check_eq("bp.in_ready_low", {31'b0, rdy_seen}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("bp.consumed", {31'b0, out_valid}, 32'd0);
    check_eq("bp.idle_after", {31'b0, in_ready}, 32'd1);
    check_eq("bp.hold_angle", sx17(out_angle), -6434);
    acc_cyc   = cyc;
    st_before = st_count;
    @(negedge clk);
    in_valid = 1'b0;
    finish_txn("bp_zero", 0, 32'd0, 1, 0, 0, 0);

    // Reset in WAIT_B, then a full drain before the next accept
    start_txn(16'd200, 16'd300, 16'd5000, 32'd360);
    repeat (80) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mrst.out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("mrst.in_ready",  {31'b0, in_ready},  32'd0);
    check_eq("mrst.core_func", {28'b0, core_func}, 32'd0);
    check_eq("mrst.core_x",    sx16(core_x),       32'd0);
    @(negedge clk);
    @(negedge clk);
    in_x     = 16'd200;
    in_y     = 16'd300;
    in_valid = 1'b1;
    rst      = 1'b0;
    measure_drain("drain1");
    acc_cyc   = cyc;
    st_before = st_count;
    @(negedge clk);
    in_valid = 1'b0;
    finish_txn("post_rst", 5000, 32'd360, 2 * L + 3, 200, 300, 2);

    check_eq("st_back_to_back", st_double, 32'd0);
    check_eq("core_req_stable", unstable, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
